// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle MIPS control FSM with memory-ready stretching and fault detection
module mips_mc_controller #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_alu_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_instr_done,
  output logic       o_fault,
  output logic [3:0] o_state
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_FAULT  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [3:0]    r_state;
  logic [3:0]    w_next;
  logic [3:0]    w_wait;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;

  // the last allowed waiting cycle without a ready ends in FAULT; ready on that cycle still wins
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1)) && !i_mem_ready;
  assign w_wait    = w_timeout ? S_FAULT : r_state;
  assign o_state   = r_state;

  // next-state decode; only memory states self-loop, FAULT absorbs
  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : w_wait;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:    w_next = S_EXEC;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:      w_next = S_BRANCH;
          OP_ADDI:     w_next = S_ADDIEX;
          OP_J:        w_next = S_JUMP;
          default:     w_next = S_FAULT;
        endcase
      end
      S_MEMADR: w_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = i_mem_ready ? S_MEMWB : w_wait;
      S_MEMWR:  w_next = i_mem_ready ? S_FETCH : w_wait;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
      default:  w_next = S_FAULT;
    endcase
  end

  // state register; reset abandons any instruction in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // wait counter restarts whenever the state changes, so it clears on entry to each memory state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  // Moore control outputs; FETCH exit, MEMWR completion and BRANCH pc_en also look at inputs
  always_comb begin
    o_pc_en      = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_ir_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'd0;
    o_alu_op     = 2'd0;
    o_pc_src     = 2'd0;
    o_instr_done = 1'b0;
    o_fault      = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = 2'd1;
        o_ir_write  = i_mem_ready;
        o_pc_en     = i_mem_ready;
      end
      S_DECODE: o_alu_src_b = 2'd3;
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        o_iord     = 1'b1;
        o_mem_read = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_iord       = 1'b1;
        o_mem_write  = 1'b1;
        o_instr_done = i_mem_ready;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = 2'd2;
      end
      S_ALUWB: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 1'b1;
        o_instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a  = 1'b1;
        o_alu_op     = 2'd1;
        o_pc_src     = 2'd1;
        o_pc_en      = i_alu_zero;
        o_instr_done = 1'b1;
      end
      S_ADDIWB: begin
        o_reg_write  = 1'b1;
        o_instr_done = 1'b1;
      end
      S_JUMP: begin
        o_pc_src     = 2'd2;
        o_pc_en      = 1'b1;
        o_instr_done = 1'b1;
      end
      S_FAULT: o_fault = 1'b1;
      default: o_fault = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed per-cycle vectors checked through an expectation queue
module tb_mips_mc_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       instr_done, fault;
  logic [3:0] state;

  mips_mc_controller #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_alu_zero(alu_zero), .i_mem_ready(mem_ready),
    .o_pc_en(pc_en), .o_iord(iord), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_ir_write(ir_write), .o_reg_write(reg_write), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op), .o_pc_src(pc_src),
    .o_instr_done(instr_done), .o_fault(fault), .o_state(state)
  );

  always #5 clk = ~clk;

  // control word: pc_en iord mem_read mem_write ir_write reg_write reg_dst mem_to_reg alu_src_a
  //               _ alu_src_b _ alu_op _ pc_src _ instr_done fault
  localparam logic [16:0] C_ZERO   = 17'b000000000_00_00_00_00;
  localparam logic [16:0] C_FETCHW = 17'b001000000_01_00_00_00;
  localparam logic [16:0] C_FETCHG = 17'b101010000_01_00_00_00;
  localparam logic [16:0] C_DECODE = 17'b000000000_11_00_00_00;
  localparam logic [16:0] C_ADR    = 17'b000000001_10_00_00_00;
  localparam logic [16:0] C_MEMRD  = 17'b011000000_00_00_00_00;
  localparam logic [16:0] C_MEMWB  = 17'b000001010_00_00_00_10;
  localparam logic [16:0] C_MEMWRW = 17'b010100000_00_00_00_00;
  localparam logic [16:0] C_MEMWRG = 17'b010100000_00_00_00_10;
  localparam logic [16:0] C_EXEC   = 17'b000000001_00_10_00_00;
  localparam logic [16:0] C_ALUWB  = 17'b000001100_00_00_00_10;
  localparam logic [16:0] C_BRT    = 17'b100000001_00_01_01_10;
  localparam logic [16:0] C_BRN    = 17'b000000001_00_01_01_10;
  localparam logic [16:0] C_ADDIWB = 17'b000001000_00_00_00_10;
  localparam logic [16:0] C_JUMP   = 17'b100000000_00_00_10_10;
  localparam logic [16:0] C_FAULT  = 17'b000000000_00_00_00_01;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic [20:0] q_exp[$];
  string       q_name[$];
  int          checks = 0;
  int          passes = 0;

  wire [20:0] w_got = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, fault};

  // one clock cycle: inputs applied just after the edge, expectation for that cycle queued
  task automatic cyc(input string nm, input logic rn, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [3:0] es, input logic [16:0] ec);
    @(posedge clk);
    #1;
    rst_n = rn;
    opcode = op;
    alu_zero = z;
    mem_ready = rdy;
    q_exp.push_back({es, ec});
    q_name.push_back(nm);
  endtask

  // monitor: compares each queued expectation against the outputs mid-cycle
  initial begin
    logic [20:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (q_exp.size() != 0) begin
        e = q_exp.pop_front();
        nm = q_name.pop_front();
        checks++;
        if (w_got === e) passes++;
        else $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                      nm, w_got[20:17], w_got[16:0], e[20:17], e[16:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc("reset_idle0", 0, OP_R, 0, 0, 4'd0, C_ZERO);
    cyc("reset_idle1", 0, OP_R, 0, 1, 4'd0, C_ZERO);
    cyc("release_idle", 1, OP_R, 0, 1, 4'd0, C_ZERO);
    // addi: 4 cycles
    cyc("addi_fetch", 1, OP_ADDI, 0, 1, 4'd1, C_FETCHG);
    cyc("addi_decode", 1, OP_ADDI, 0, 1, 4'd2, C_DECODE);
    cyc("addi_ex", 1, OP_ADDI, 0, 1, 4'd10, C_ADR);
    cyc("addi_wb", 1, OP_ADDI, 0, 1, 4'd11, C_ADDIWB);
    // lw with three wait cycles in MEMRD: 8 cycles
    cyc("lw_fetch", 1, OP_LW, 0, 1, 4'd1, C_FETCHG);
    cyc("lw_decode", 1, OP_LW, 0, 1, 4'd2, C_DECODE);
    cyc("lw_adr", 1, OP_LW, 0, 1, 4'd3, C_ADR);
    for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1, OP_LW, 0, 0, 4'd4, C_MEMRD);
    cyc("lw_memrd_go", 1, OP_LW, 0, 1, 4'd4, C_MEMRD);
    cyc("lw_memwb", 1, OP_LW, 0, 1, 4'd5, C_MEMWB);
    // sw with one wait cycle
    cyc("sw_fetch", 1, OP_SW, 0, 1, 4'd1, C_FETCHG);
    cyc("sw_decode", 1, OP_SW, 0, 1, 4'd2, C_DECODE);
    cyc("sw_adr", 1, OP_SW, 0, 1, 4'd3, C_ADR);
    cyc("sw_memwr_wait", 1, OP_SW, 0, 0, 4'd6, C_MEMWRW);
    cyc("sw_memwr_go", 1, OP_SW, 0, 1, 4'd6, C_MEMWRG);
    // R-type
    cyc("r_fetch", 1, OP_R, 0, 1, 4'd1, C_FETCHG);
    cyc("r_decode", 1, OP_R, 0, 1, 4'd2, C_DECODE);
    cyc("r_exec", 1, OP_R, 0, 1, 4'd7, C_EXEC);
    cyc("r_aluwb", 1, OP_R, 0, 1, 4'd8, C_ALUWB);
    // beq taken then not taken
    cyc("beq1_fetch", 1, OP_BEQ, 1, 1, 4'd1, C_FETCHG);
    cyc("beq1_decode", 1, OP_BEQ, 1, 1, 4'd2, C_DECODE);
    cyc("beq1_branch", 1, OP_BEQ, 1, 1, 4'd9, C_BRT);
    cyc("beq0_fetch", 1, OP_BEQ, 0, 1, 4'd1, C_FETCHG);
    cyc("beq0_decode", 1, OP_BEQ, 0, 1, 4'd2, C_DECODE);
    cyc("beq0_branch", 1, OP_BEQ, 0, 1, 4'd9, C_BRN);
    // jump
    cyc("j_fetch", 1, OP_J, 0, 1, 4'd1, C_FETCHG);
    cyc("j_decode", 1, OP_J, 0, 1, 4'd2, C_DECODE);
    cyc("j_jump", 1, OP_J, 0, 1, 4'd12, C_JUMP);
    // ready arrives on the 16th FETCH cycle: no fault
    for (int i = 0; i < 15; i++) cyc("to_edge_wait", 1, OP_J, 0, 0, 4'd1, C_FETCHW);
    cyc("to_edge_go", 1, OP_J, 0, 1, 4'd1, C_FETCHG);
    cyc("to_edge_decode", 1, OP_J, 0, 1, 4'd2, C_DECODE);
    cyc("to_edge_jump", 1, OP_J, 0, 1, 4'd12, C_JUMP);
    // async reset while memWrite is high
    cyc("rst_sw_fetch", 1, OP_SW, 0, 1, 4'd1, C_FETCHG);
    cyc("rst_sw_decode", 1, OP_SW, 0, 1, 4'd2, C_DECODE);
    cyc("rst_sw_adr", 1, OP_SW, 0, 1, 4'd3, C_ADR);
    cyc("rst_sw_memwr", 1, OP_SW, 0, 0, 4'd6, C_MEMWRW);
    cyc("rst_async_idle", 0, OP_SW, 0, 0, 4'd0, C_ZERO);
    cyc("rst_release_idle", 1, OP_SW, 0, 1, 4'd0, C_ZERO);
    cyc("rst_refetch", 1, OP_J, 0, 1, 4'd1, C_FETCHG);
    cyc("rst_re_decode", 1, OP_J, 0, 1, 4'd2, C_DECODE);
    cyc("rst_re_jump", 1, OP_J, 0, 1, 4'd12, C_JUMP);
    // FETCH timeout: 16 waiting cycles then FAULT, which absorbs
    for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 1, OP_J, 0, 0, 4'd1, C_FETCHW);
    cyc("to_fault", 1, OP_J, 0, 1, 4'd15, C_FAULT);
    cyc("to_fault_hold", 1, OP_J, 0, 1, 4'd15, C_FAULT);
    cyc("to_rst_idle", 0, OP_J, 0, 1, 4'd0, C_ZERO);
    cyc("to_rel_idle", 1, OP_BAD, 0, 1, 4'd0, C_ZERO);
    // illegal opcode
    cyc("bad_fetch", 1, OP_BAD, 0, 1, 4'd1, C_FETCHG);
    cyc("bad_decode", 1, OP_BAD, 0, 1, 4'd2, C_DECODE);
    cyc("bad_fault", 1, OP_BAD, 0, 1, 4'd15, C_FAULT);
    cyc("bad_fault_hold", 1, OP_R, 1, 1, 4'd15, C_FAULT);
    cyc("bad_rst_idle", 0, OP_R, 0, 1, 4'd0, C_ZERO);
    @(negedge clk);
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
